// File: rtl/seq_alu.sv
// ============================================================================
// Module  : seq_alu
// Brief   : Handshaked ALU with registered operands, double-width result,
//           zero/carry flags and an optional iterative multiply (SEQ_ALU_MUL_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  input  logic [2:0]           op_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 carry,
  output logic                 illegal
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic [1:0]          state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                illegal_q, illegal_d;
  logic                out_valid_q, out_valid_d;

  logic                accept;
  logic [WIDTH:0]      sum_w;
  logic [WIDTH:0]      diff_w;
  logic [2*WIDTH-1:0]  alu_res;
  logic                alu_carry;
  logic                alu_illegal;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [SHW-1:0] MUL_LAST = SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic                mul_start;

  assign mul_start = accept && (op_sel == OP_MUL);
`endif

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef SEQ_ALU_MUL_EN
          state_d = mul_start ? ST_MUL : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_MUL: begin
`ifdef SEQ_ALU_MUL_EN
        if (cnt_q == MUL_LAST) begin
          state_d = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = rst_n && (state_q == ST_IDLE);
    out_valid = out_valid_q;
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign carry   = carry_q;
  assign illegal = illegal_q;

  // Function unit operates only on the captured operands, never on live inputs
  always_comb begin
    sum_w       = {1'b0, a_q} + {1'b0, b_q};
    diff_w      = {1'b0, a_q} - {1'b0, b_q};
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = {{(WIDTH-1){1'b0}}, sum_w};
        alu_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_res   = {{(WIDTH-1){1'b0}}, diff_w};
        alu_carry = diff_w[WIDTH];
      end
      OP_AND: alu_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR: alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_SHL: alu_res = {{WIDTH{1'b0}}, a_q << b_q[SHW-1:0]};
      OP_SHR: alu_res = {{WIDTH{1'b0}}, a_q >> b_q[SHW-1:0]};
      default: begin
`ifdef SEQ_ALU_MUL_EN
        alu_res   = acc_q;
        alu_carry = |acc_q[2*WIDTH-1:WIDTH];
`else
        alu_illegal = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
`ifdef SEQ_ALU_MUL_EN
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`endif

    if (accept) begin
      op_d = op_sel;
      a_d  = num1;
      b_d  = num2;
`ifdef SEQ_ALU_MUL_EN
      if (mul_start) begin
        mcand_d  = {{WIDTH{1'b0}}, num1};
        mplier_d = num2;
        acc_d    = '0;
        cnt_d    = '0;
      end
`endif
    end

`ifdef SEQ_ALU_MUL_EN
    // One multiplier bit per cycle, LSB first
    if (state_q == ST_MUL) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
`endif

    // Entering DONE means the answer is ready; it is registered one edge later
    if (state_q == ST_DONE) begin
      if (!out_valid_q) begin
        result_d    = alu_res;
        zero_d      = ~|alu_res[WIDTH-1:0];
        carry_d     = alu_carry;
        illegal_d   = alu_illegal;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_ALU_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

`default_nettype wire
